// File: rtl/nn_requant_stage.sv
// Output stage after a sequential linear layer. It captures the accumulator vector, then requantizes
// one element per cycle, publishes the parallel result bus, and streams the elements over valid/ready.
module nn_requant_stage #(
   parameter int unsigned N_OUT = 4,
   parameter int unsigned ACC_W = 20,
   parameter int unsigned OUT_W = 8,
   parameter int unsigned SHIFT = 7,
   parameter int unsigned RELU  = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_done,
   input  logic [N_OUT*ACC_W-1:0] acc_flat,
   output logic                   busy,
   output logic                   next_start,
   output logic [N_OUT*OUT_W-1:0] out_flat,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [OUT_W-1:0]       m_data,
   output logic                   m_last,
   output logic                   err_overrun
);

   localparam int unsigned IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int unsigned XW     = ACC_W + 1;
   localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_OUT - 1);
   localparam logic signed [XW-1:0] RND      = (SHIFT > 0) ? (XW'(1) << RND_SH) : XW'(0);
   localparam logic signed [XW-1:0] SAT_MAX  = XW'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [XW-1:0] SAT_MIN  = XW'(-(1 << (OUT_W - 1)));

   typedef enum logic [1:0] {IDLE, PROC, STREAM} state_t;

   state_t                   state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d, sidx_q, sidx_d;
   logic [N_OUT*ACC_W-1:0]   acc_buf, acc_buf_d;
   logic [N_OUT*OUT_W-1:0]   out_flat_d;
   logic                     busy_d, next_start_d, m_valid_d, m_last_d, err_overrun_d;
   logic [OUT_W-1:0]         m_data_d;

   // Optional ReLU, round-half-up arithmetic shift at ACC_W+1 bits, saturate to OUT_W.
   function automatic logic [OUT_W-1:0] requant(input logic [ACC_W-1:0] a);
      logic signed [XW-1:0] x;
      logic signed [XW-1:0] y;
      logic [OUT_W-1:0]     r;
      x = {a[ACC_W-1], a};
      if (RELU != 0 && x[XW-1]) x = '0;
      y = (x + RND) >>> SHIFT;
      if (y > SAT_MAX)      r = SAT_MAX[OUT_W-1:0];
      else if (y < SAT_MIN) r = SAT_MIN[OUT_W-1:0];
      else                  r = y[OUT_W-1:0];
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         sidx_q      <= '0;
         acc_buf     <= '0;
         out_flat    <= '0;
         busy        <= 1'b0;
         next_start  <= 1'b0;
         m_valid     <= 1'b0;
         m_data      <= '0;
         m_last      <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         sidx_q      <= sidx_d;
         acc_buf     <= acc_buf_d;
         out_flat    <= out_flat_d;
         busy        <= busy_d;
         next_start  <= next_start_d;
         m_valid     <= m_valid_d;
         m_data      <= m_data_d;
         m_last      <= m_last_d;
         err_overrun <= err_overrun_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      sidx_d        = sidx_q;
      acc_buf_d     = acc_buf;
      out_flat_d    = out_flat;
      next_start_d  = 1'b0;
      err_overrun_d = err_overrun | (in_done & (state_q != IDLE));

      case (state_q)
         IDLE: begin
            if (in_done) begin
               acc_buf_d = acc_flat;
               idx_d     = '0;
               state_d   = PROC;
            end
         end
         PROC: begin
            out_flat_d[idx_q*OUT_W +: OUT_W] = requant(acc_buf[idx_q*ACC_W +: ACC_W]);
            if (idx_q == LAST_IDX) begin
               sidx_d       = '0;
               next_start_d = 1'b1;
               state_d      = STREAM;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         STREAM: begin
            if (m_valid && m_ready) begin
               if (sidx_q == LAST_IDX) state_d = IDLE;
               else                    sidx_d  = sidx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Stream outputs follow the next state so the first beat already sees the final element.
      busy_d    = (state_d != IDLE);
      m_valid_d = (state_d == STREAM);
      m_last_d  = (state_d == STREAM) && (sidx_d == LAST_IDX);
      m_data_d  = m_valid_d ? out_flat_d[sidx_d*OUT_W +: OUT_W] : m_data;
   end

endmodule

// File: tb/tb_nn_requant_stage.sv
// Randomized scoreboard bench for nn_requant_stage; a ReLU and a signed instance share all stimulus.
module tb_nn_requant_stage;

   localparam int unsigned N_OUT = 4;
   localparam int unsigned ACC_W = 20;
   localparam int unsigned OUT_W = 8;
   localparam int unsigned SHIFT = 7;
   localparam int unsigned FLAT  = N_OUT * OUT_W;

   typedef struct packed {
      logic [OUT_W-1:0] d0;
      logic [OUT_W-1:0] d1;
      logic             last;
   } beat_t;

   typedef struct packed {
      logic [FLAT-1:0] f0;
      logic [FLAT-1:0] f1;
   } flat_t;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   in_done = 1'b0;
   logic                   m_ready = 1'b0;
   logic [N_OUT*ACC_W-1:0] acc_flat = '0;
   logic [1:0]             busy_w, ns_w, mv_w, ml_w, err_w;
   logic [OUT_W-1:0]       md_w [2];
   logic [FLAT-1:0]        of_w [2];

   beat_t beat_q[$];
   flat_t flat_q[$];
   flat_t cur_flat = '0;
   int    vec [N_OUT];
   int    total = 0;
   int    bad = 0;
   int    cyc = 0;
   int    t_start = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   nn_requant_stage #(.N_OUT(N_OUT), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .RELU(1)) u_relu (
      .clk(clk), .rst(rst), .in_done(in_done), .acc_flat(acc_flat), .busy(busy_w[0]),
      .next_start(ns_w[0]), .out_flat(of_w[0]), .m_valid(mv_w[0]), .m_ready(m_ready),
      .m_data(md_w[0]), .m_last(ml_w[0]), .err_overrun(err_w[0]));

   nn_requant_stage #(.N_OUT(N_OUT), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .RELU(0)) u_sgn (
      .clk(clk), .rst(rst), .in_done(in_done), .acc_flat(acc_flat), .busy(busy_w[1]),
      .next_start(ns_w[1]), .out_flat(of_w[1]), .m_valid(mv_w[1]), .m_ready(m_ready),
      .m_data(md_w[1]), .m_last(ml_w[1]), .err_overrun(err_w[1]));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: real-valued rounding (floor of x/2^S + 1/2), then clamp to the output range.
   function automatic int model(input int x_in, input bit relu);
      int x;
      int y;
      int lo;
      int hi;
      x  = (relu && x_in < 0) ? 0 : x_in;
      y  = $rtoi($floor(real'(x) / real'(1 << SHIFT) + 0.5));
      lo = -(1 << (OUT_W - 1));
      hi = (1 << (OUT_W - 1)) - 1;
      if (y > hi) y = hi;
      if (y < lo) y = lo;
      return y;
   endfunction

   function automatic int rand_acc();
      int v;
      case ($urandom_range(0, 2))
         0:       v = int'($urandom_range(0, (1 << ACC_W) - 1)) - (1 << (ACC_W - 1));
         1:       v = int'($urandom_range(0, 2000)) - 1000;
         default: v = int'($urandom_range(0, 40000)) - 20000;
      endcase
      return v;
   endfunction

   task automatic issue();
      flat_t f;
      beat_t b;
      @(posedge clk); #1;
      in_done = 1'b1;
      for (int i = 0; i < int'(N_OUT); i++) begin
         acc_flat[i*ACC_W +: ACC_W] = ACC_W'(vec[i]);
         f.f0[i*OUT_W +: OUT_W] = OUT_W'(model(vec[i], 1'b1));
         f.f1[i*OUT_W +: OUT_W] = OUT_W'(model(vec[i], 1'b0));
      end
      flat_q.push_back(f);
      for (int i = 0; i < int'(N_OUT); i++) begin
         b.d0   = f.f0[i*OUT_W +: OUT_W];
         b.d1   = f.f1[i*OUT_W +: OUT_W];
         b.last = (i == int'(N_OUT) - 1);
         beat_q.push_back(b);
      end
      @(posedge clk); #1;
      t_start = cyc;
      in_done = 1'b0;
   endtask

   task automatic drain(input bit rnd);
      int n = 0;
      do begin
         @(posedge clk); #1;
         m_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         n++;
      end while ((busy_w != 2'b00 || beat_q.size() != 0) && n < 400);
      chk("drain_idle", 64'(busy_w == 2'b00 && beat_q.size() == 0), 64'd1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"}, 64'(busy_w), 64'd0);
      chk({tag, "_next_start"}, 64'(ns_w), 64'd0);
      chk({tag, "_m_valid"}, 64'(mv_w), 64'd0);
      chk({tag, "_m_last"}, 64'(ml_w), 64'd0);
      chk({tag, "_err"}, 64'(err_w), 64'd0);
      chk({tag, "_out0"}, 64'(of_w[0]), 64'd0);
      chk({tag, "_out1"}, 64'(of_w[1]), 64'd0);
   endtask

   task automatic rand_vec();
      for (int i = 0; i < int'(N_OUT); i++) vec[i] = rand_acc();
   endtask

   // Monitor: pops the scoreboard on every handshake and next_start, checks stall stability.
   logic             stall_prev = 1'b0;
   logic             idle_chk = 1'b0;
   logic [OUT_W-1:0] prev_md [2];
   logic [1:0]       prev_ml = '0;

   always @(negedge clk) begin
      beat_t b;
      flat_t f;
      if (rst) begin
         stall_prev = 1'b0;
         idle_chk   = 1'b0;
      end else begin
         if (idle_chk) begin
            chk("idle_busy", 64'(busy_w), 64'd0);
            chk("idle_valid", 64'(mv_w), 64'd0);
         end
         idle_chk = 1'b0;
         if (stall_prev) begin
            chk("stall_data0", 64'(md_w[0]), 64'(prev_md[0]));
            chk("stall_data1", 64'(md_w[1]), 64'(prev_md[1]));
            chk("stall_last", 64'(ml_w), 64'(prev_ml));
            chk("stall_valid", 64'(mv_w), 64'd3);
         end
         if (ns_w != 2'b00) begin
            chk("ns_pair", 64'(ns_w), 64'd3);
            if (flat_q.size() == 0) begin
               chk("ns_unexpected", 64'(ns_w), 64'd0);
            end else begin
               f = flat_q.pop_front();
               chk("ns_latency", 64'(cyc - t_start), 64'(N_OUT));
               chk("flat_relu", 64'(of_w[0]), 64'(f.f0));
               chk("flat_sgn", 64'(of_w[1]), 64'(f.f1));
               cur_flat = f;
            end
         end
         if (mv_w != 2'b00) begin
            chk("valid_pair", 64'(mv_w), 64'd3);
            chk("hold_relu", 64'(of_w[0]), 64'(cur_flat.f0));
            chk("hold_sgn", 64'(of_w[1]), 64'(cur_flat.f1));
            if (m_ready) begin
               if (beat_q.size() == 0) begin
                  chk("beat_unexpected", 64'(mv_w), 64'd0);
               end else begin
                  b = beat_q.pop_front();
                  chk("data_relu", 64'(md_w[0]), 64'(b.d0));
                  chk("data_sgn", 64'(md_w[1]), 64'(b.d1));
                  chk("last", 64'(ml_w), 64'({2{b.last}}));
                  if (b.last) idle_chk = 1'b1;
               end
            end
         end
         stall_prev = (mv_w != 2'b00) && !m_ready;
         prev_md    = md_w;
         prev_ml    = ml_w;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("reset");
      rst = 1'b0;

      // Rounding and ReLU
      vec = '{64, 63, 300, -200};
      issue();
      drain(1'b0);
      chk("t1_relu", 64'(of_w[0]), 64'({8'h00, 8'h02, 8'h00, 8'h01}));

      // Saturation
      vec = '{20000, 16191, 16192, 524287};
      issue();
      drain(1'b0);
      chk("t2_relu", 64'(of_w[0]), 64'({8'h7F, 8'h7F, 8'h7E, 8'h7F}));

      // Signed path
      vec = '{-64, -65, -20000, -128};
      issue();
      drain(1'b0);
      chk("t3_sgn", 64'(of_w[1]), 64'({8'hFF, 8'h80, 8'hFF, 8'h00}));
      chk("t3_relu", 64'(of_w[0]), 64'd0);
      chk("t3_err", 64'(err_w), 64'd0);

      // Random frames with random backpressure
      repeat (20) begin
         rand_vec();
         issue();
         drain(1'b1);
      end

      // Back-to-back: second in_done in the first IDLE cycle after the final handshake
      m_ready = 1'b1;
      rand_vec();
      issue();
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(mv_w[0] && ml_w[0]) && n < 50);
      chk("b2b_last_seen", 64'(mv_w[0] && ml_w[0]), 64'd1);
      rand_vec();
      issue();
      drain(1'b0);
      chk("b2b_err", 64'(err_w), 64'd0);

      // Backpressure plus overrun during STREAM
      m_ready = 1'b0;
      rand_vec();
      issue();
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (mv_w[0] == 1'b0 && n < 50);
      chk("bp_valid_seen", 64'(mv_w[0]), 64'd1);
      @(posedge clk); #1;
      in_done = 1'b1;
      for (int i = 0; i < int'(N_OUT); i++) acc_flat[i*ACC_W +: ACC_W] = ACC_W'(rand_acc());
      @(posedge clk); #1;
      in_done = 1'b0;
      @(posedge clk); #1;
      m_ready = 1'b1;
      drain(1'b0);
      chk("overrun_err", 64'(err_w), 64'd3);

      // Reset during PROC at idx 2
      rand_vec();
      issue();
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      flat_q.delete();
      beat_q.delete();
      @(posedge clk); #1;
      chk_reset("rst_mid");
      rst = 1'b0;
      repeat (N_OUT + 4) @(posedge clk);
      #1;
      chk("rst_mid_idle", 64'(busy_w), 64'd0);
      rand_vec();
      issue();
      drain(1'b1);
      chk("post_rst_err", 64'(err_w), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
